// File: rtl/glow_pkg.sv
// Shared types and helpers for the glow-cell bank scheduler.
package glow_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ERASE,
        ST_SETTLE,
        ST_CHARGE,
        ST_DONE
    } glow_state_t;

    localparam logic [7:0] SENSE_DARK = 8'hff;

    function automatic int unsigned cell_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/glow_refresh_timer.sv
// Free-running refresh slot timer; pulses once per REFRESH_CYCLES and walks a
// round-robin cell pointer.
module glow_refresh_timer
    import glow_pkg::*;
#(
    parameter int unsigned NUM_CELLS      = 4,
    parameter int unsigned REFRESH_CYCLES = 8000000
) (
    input  logic                                clk,
    input  logic                                reset,
    output logic                                tick,
    output logic [cell_idx_w(NUM_CELLS)-1:0]    ptr
);

    localparam int unsigned IW = cell_idx_w(NUM_CELLS);

    logic [31:0] cnt;

    assign tick = (cnt == 32'(REFRESH_CYCLES - 1));

    // NUM_CELLS is a power of two, so the pointer wraps naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            ptr <= '0;
        end else if (tick) begin
            cnt <= '0;
            ptr <= ptr + IW'(1);
        end else begin
            cnt <= cnt + 32'd1;
        end
    end

endmodule

// File: rtl/glow_bank_scheduler.sv
// Sequences erase/charge/refresh of glow byte cells over one shared LED path;
// only one bank is ever lit.
module glow_bank_scheduler
    import glow_pkg::*;
#(
    parameter int unsigned NUM_CELLS      = 4,
    parameter int unsigned CHARGE_CYCLES  = 4000000,
    parameter int unsigned REFRESH_CYCLES = 8000000,
    parameter int unsigned ERASE_TIMEOUT  = 16000000
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                wr_req,
    input  logic [cell_idx_w(NUM_CELLS)-1:0]    wr_addr,
    input  logic [7:0]                          wr_data,
    output logic                                wr_ack,
    input  logic [7:0]                          sense,
    output logic [cell_idx_w(NUM_CELLS)-1:0]    sel,
    output logic [NUM_CELLS-1:0]                led_en,
    output logic [7:0]                          glow_leds,
    output logic [NUM_CELLS-1:0]                busy,
    output logic                                err
);

    localparam int unsigned IW = cell_idx_w(NUM_CELLS);
    typedef logic [IW-1:0] idx_t;

    glow_state_t          state, state_d;
    logic [31:0]          cnt, cnt_d;
    logic [7:0]           shadow    [NUM_CELLS];
    logic [7:0]           pend_data [NUM_CELLS];
    logic [NUM_CELLS-1:0] pend, pend_d;
    logic [NUM_CELLS-1:0] ref_due, due_d;
    logic [NUM_CELLS-1:0] zero_due;
    logic                 tick;
    idx_t                 ptr;
    logic                 pend_hit, due_hit;
    idx_t                 pend_idx, due_idx;
    logic                 pick_pend, pick_ref, err_set;
    logic [NUM_CELLS-1:0] led_en_d;
    logic [7:0]           glow_d;

    glow_refresh_timer #(
        .NUM_CELLS      (NUM_CELLS),
        .REFRESH_CYCLES (REFRESH_CYCLES)
    ) u_refresh_timer (
        .clk   (clk),
        .reset (reset),
        .tick  (tick),
        .ptr   (ptr)
    );

    // Lowest-index arbitration over pending writes and due refreshes.
    always_comb begin
        pend_hit = 1'b0;
        pend_idx = '0;
        due_hit  = 1'b0;
        due_idx  = '0;
        zero_due = '0;
        for (int unsigned i = 0; i < NUM_CELLS; i++) begin
            if (pend[i] && !pend_hit) begin
                pend_hit = 1'b1;
                pend_idx = idx_t'(i);
            end
            if (ref_due[i] && (shadow[i] != '0) && !due_hit) begin
                due_hit = 1'b1;
                due_idx = idx_t'(i);
            end
            zero_due[i] = ref_due[i] && (shadow[i] == '0);
        end
    end

    always_comb begin
        state_d   = state;
        cnt_d     = cnt + 32'd1;
        pick_pend = 1'b0;
        pick_ref  = 1'b0;
        err_set   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                cnt_d = '0;
                if (pend_hit) begin
                    pick_pend = 1'b1;
                    state_d   = ST_ERASE;
                end else if (due_hit) begin
                    pick_ref = 1'b1;
                    state_d  = ST_SETTLE;
                end
            end
            ST_ERASE: begin
                if (sense == SENSE_DARK) begin
                    state_d = ST_SETTLE;
                end else if (cnt == 32'(ERASE_TIMEOUT - 1)) begin
                    err_set = 1'b1;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                cnt_d   = '0;
                state_d = (shadow[sel] == '0) ? ST_DONE : ST_CHARGE;
            end
            ST_CHARGE: begin
                if (cnt == 32'(CHARGE_CYCLES - 1)) state_d = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // CHARGE is only entered from SETTLE, so sel and its shadow are stable here.
        led_en_d = '0;
        glow_d   = '0;
        if (state_d == ST_CHARGE) begin
            led_en_d[sel] = 1'b1;
            glow_d        = shadow[sel];
        end
    end

    // Refresh marks first, pickup clears next, a new write always lands last.
    always_comb begin
        pend_d = pend;
        due_d  = ref_due;
        if (tick && !(wr_req && (wr_addr == ptr))) due_d[ptr] = 1'b1;
        if (pick_pend) begin
            pend_d[pend_idx] = 1'b0;
            due_d[pend_idx]  = 1'b0;
        end
        if (pick_ref) due_d[due_idx] = 1'b0;
        if ((state == ST_IDLE) && !pend_hit) due_d = due_d & ~zero_due;
        if (wr_req) pend_d[wr_addr] = 1'b1;
    end

    always_comb begin
        busy = pend;
        if (state != ST_IDLE) busy[sel] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            sel       <= '0;
            pend      <= '0;
            ref_due   <= '0;
            err       <= 1'b0;
            wr_ack    <= 1'b0;
            led_en    <= '0;
            glow_leds <= '0;
            for (int unsigned i = 0; i < NUM_CELLS; i++) begin
                shadow[i]    <= '0;
                pend_data[i] <= '0;
            end
        end else begin
            cnt       <= cnt_d;
            wr_ack    <= wr_req;
            led_en    <= led_en_d;
            glow_leds <= glow_d;
            pend      <= pend_d;
            ref_due   <= due_d;
            if (err_set) err <= 1'b1;
            if (pick_pend) begin
                sel              <= pend_idx;
                shadow[pend_idx] <= pend_data[pend_idx];
            end else if (pick_ref) begin
                sel <= due_idx;
            end
            if (wr_req) pend_data[wr_addr] <= wr_data;
        end
    end

endmodule
